// File: rtl/link_tx_queue_pkg.sv
// Shared definitions for the link transmit queue: message width and FSM state encodings.
package link_tx_queue_pkg;

    localparam int MESSAGE_SIZE = 8;

    typedef enum logic [1:0] {
        LTQ_IDLE      = 2'd0,
        LTQ_ISSUE     = 2'd1,
        LTQ_WAIT_DONE = 2'd2
    } ltq_state_e;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int ltq_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/link_tx_queue_if.sv
// Host-side valid/ready push channel plus the send/data/done handshake toward the link block.
interface link_tx_queue_if #(
    parameter int MSG_W = link_tx_queue_pkg::MESSAGE_SIZE
);
    logic             in_valid;
    logic [MSG_W-1:0] in_data;
    logic             in_ready;
    logic             link_send;
    logic [MSG_W-1:0] link_data;
    logic             link_done;

    // master is the surrounding environment (host and link), slave is the queue
    modport master (
        output in_valid, in_data, link_done,
        input  in_ready, link_send, link_data
    );

    modport slave (
        input  in_valid, in_data, link_done,
        output in_ready, link_send, link_data
    );
endinterface

// File: rtl/msg_fifo.sv
// Synchronous message FIFO with head-of-queue data out; shared by the TX and RX message paths.
module msg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == COUNT_FULL);
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[head];

    // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + AW'(1);
            if (do_pop)  head <= head + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only read after it has been written.
    always_ff @(posedge clock) begin
        if (do_push) mem[tail] <= push_data;
    end

endmodule

// File: rtl/link_tx_queue.sv
// Transmit message queue feeding the link block: buffers host messages, issues them one at a time,
// retries on a missing transmit-done and drops the message after the retry budget is spent.
module link_tx_queue
    import link_tx_queue_pkg::*;
#(
    parameter int MSG_W          = MESSAGE_SIZE,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    link_tx_queue_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [15:0]                sent_count
);
    localparam int TW = ltq_bits(TIMEOUT_CYCLES);
    localparam int RW = ltq_bits(MAX_RETRY + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    ltq_state_e       state, state_next;
    logic [TW-1:0]    timer, timer_next;
    logic [RW-1:0]    retry, retry_next;
    logic [MSG_W-1:0] link_data_q, link_data_next;
    logic             done_q;
    logic             done_rise;
    logic             complete;
    logic             drop;
    logic             full;
    logic             empty;
    logic [MSG_W-1:0] head_data;

    msg_fifo #(
        .WIDTH (MSG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (bus.in_valid),
        .pop       (complete || drop),
        .push_data (bus.in_data),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign done_rise     = bus.link_done && !done_q;
    assign bus.in_ready  = !full;
    assign bus.link_send = (state == LTQ_ISSUE);
    assign bus.link_data = link_data_q;
    assign busy          = (state != LTQ_IDLE) || !empty;

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_next     = state;
        timer_next     = timer;
        retry_next     = retry;
        link_data_next = link_data_q;
        complete       = 1'b0;
        drop           = 1'b0;
        case (state)
            LTQ_IDLE: begin
                if (!empty) begin
                    link_data_next = head_data;
                    timer_next     = '0;
                    state_next     = LTQ_ISSUE;
                end
            end
            LTQ_ISSUE: begin
                timer_next = '0;
                state_next = LTQ_WAIT_DONE;
            end
            LTQ_WAIT_DONE: begin
                // A done edge on the final timer cycle still counts as success.
                if (done_rise) begin
                    complete   = 1'b1;
                    retry_next = '0;
                    state_next = LTQ_IDLE;
                end else if (timer == TIMER_LAST) begin
                    if (retry < RETRY_MAX) begin
                        retry_next = retry + RW'(1);
                        state_next = LTQ_ISSUE;
                    end else begin
                        drop       = 1'b1;
                        retry_next = '0;
                        state_next = LTQ_IDLE;
                    end
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            default: state_next = LTQ_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= LTQ_IDLE;
            timer       <= '0;
            retry       <= '0;
            link_data_q <= '0;
            done_q      <= 1'b0;
            timeout_err <= 1'b0;
            sent_count  <= '0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            retry       <= retry_next;
            link_data_q <= link_data_next;
            done_q      <= bus.link_done;
            timeout_err <= drop;
            if (complete) sent_count <= sent_count + 16'd1;
        end
    end

endmodule
